// File: rtl/lock_controller.sv
// Lock controller: compares 4-digit BCD entries against a stored password,
// tracks consecutive failures, and drives unlock / set-password / lockout status.
// Every output is a flop, so all status changes appear one cycle after the
// inputs that caused them.
module lock_controller #(
    parameter logic [15:0] DEFAULT_PASSWORD = 16'h1234,
    parameter int          MAX_ATTEMPTS     = 3,
    parameter int          UNLOCK_CYCLES    = 50000000,
    parameter int          LOCKOUT_CYCLES   = 500000000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [15:0]                       digits,
    input  logic                              storageFull,
    input  logic                              enter,
    input  logic                              newPassword,
    output logic                              clear_entry,
    output logic                              unlocked,
    output logic                              set_mode,
    output logic                              alarm,
    output logic                              pw_changed,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count
);

    localparam int FAIL_W    = $clog2(MAX_ATTEMPTS + 1);
    localparam int MAX_CYC   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_RAW = $clog2(MAX_CYC);
    localparam int TIMER_W   = (TIMER_RAW < 1) ? 1 : TIMER_RAW;

    localparam logic [FAIL_W-1:0]  FAIL_LAST    = FAIL_W'(MAX_ATTEMPTS - 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LAST  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_SET_PW   = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    state_t              r_state;
    logic [15:0]         r_stored_pw;
    logic [FAIL_W-1:0]   r_fail_count;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_clear_entry;
    logic                r_unlocked;
    logic                r_set_mode;
    logic                r_alarm;
    logic                r_pw_changed;

    state_t              w_state_next;
    logic [15:0]         w_pw_next;
    logic [FAIL_W-1:0]   w_fail_next;
    logic [TIMER_W-1:0]  w_timer_next;
    logic                w_clear_next;
    logic                w_pw_changed_next;
    logic                w_unlock_expired;
    logic                w_lockout_expired;

    // Expiry uses >= so a timer held at its limit still expires on a later cycle.
    assign w_unlock_expired  = (r_timer >= UNLOCK_LAST);
    assign w_lockout_expired = (r_timer >= LOCKOUT_LAST);

    // Next-state, password, failure count, timer and pulse outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        w_state_next      = r_state;
        w_pw_next         = r_stored_pw;
        w_fail_next       = r_fail_count;
        w_timer_next      = (r_state == ST_LOCKED) ? '0 : r_timer + 1'b1;
        w_clear_next      = 1'b0;
        w_pw_changed_next = 1'b0;

        unique case (r_state)
            ST_LOCKED: begin
                // newPassword has no meaning while locked.
                if (enter) begin
                    w_clear_next = 1'b1;
                    if (storageFull && (digits == r_stored_pw)) begin
                        w_state_next = ST_UNLOCKED;
                        w_fail_next  = '0;
                    end else if (r_fail_count == FAIL_LAST) begin
                        w_state_next = ST_LOCKOUT;
                        w_fail_next  = r_fail_count + 1'b1;
                    end else begin
                        w_fail_next  = r_fail_count + 1'b1;
                    end
                end
            end

            ST_UNLOCKED: begin
                // enter outranks both newPassword and the expiry timeout.
                if (enter) begin
                    w_state_next = ST_LOCKED;
                    w_clear_next = 1'b1;
                end else if (newPassword) begin
                    w_state_next = ST_SET_PW;
                    w_clear_next = 1'b1;
                end else if (w_unlock_expired) begin
                    w_state_next = ST_LOCKED;
                end
            end

            ST_SET_PW: begin
                if (enter) begin
                    w_clear_next = 1'b1;
                    if (storageFull) begin
                        w_pw_next         = digits;
                        w_pw_changed_next = 1'b1;
                        w_state_next      = ST_LOCKED;
                    end else if (w_unlock_expired) begin
                        // Short entry on the expiry cycle: hold the timer so the
                        // timeout still fires on the next idle cycle instead of wrapping.
                        w_timer_next = r_timer;
                    end
                end else if (w_unlock_expired) begin
                    w_state_next = ST_LOCKED;
                end
            end

            ST_LOCKOUT: begin
                // Keypad entries are only flushed; the timeout is the sole way out.
                w_clear_next = enter;
                if (w_lockout_expired) begin
                    w_state_next = ST_LOCKED;
                    w_fail_next  = '0;
                end
            end

            default: w_state_next = ST_LOCKED;
        endcase

        if (w_state_next != r_state) begin
            w_timer_next = '0;
        end
    end

    // State, password, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            r_state       <= ST_LOCKED;
            r_stored_pw   <= DEFAULT_PASSWORD;
            r_fail_count  <= '0;
            r_timer       <= '0;
            r_clear_entry <= 1'b0;
            r_unlocked    <= 1'b0;
            r_set_mode    <= 1'b0;
            r_alarm       <= 1'b0;
            r_pw_changed  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_stored_pw   <= w_pw_next;
            r_fail_count  <= w_fail_next;
            r_timer       <= w_timer_next;
            r_clear_entry <= w_clear_next;
            r_unlocked    <= (w_state_next == ST_UNLOCKED);
            r_set_mode    <= (w_state_next == ST_SET_PW);
            r_alarm       <= (w_state_next == ST_LOCKOUT);
            r_pw_changed  <= w_pw_changed_next;
        end
    end

    assign clear_entry = r_clear_entry;
    assign unlocked    = r_unlocked;
    assign set_mode    = r_set_mode;
    assign alarm       = r_alarm;
    assign pw_changed  = r_pw_changed;
    assign fail_count  = r_fail_count;

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller with short timeouts.
module tb_lock_controller;

    localparam int MAX_ATTEMPTS   = 3;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int FAIL_W         = $clog2(MAX_ATTEMPTS + 1);

    logic              clk;
    logic              reset;
    logic [15:0]       digits;
    logic              storageFull;
    logic              enter;
    logic              newPassword;
    logic              clear_entry;
    logic              unlocked;
    logic              set_mode;
    logic              alarm;
    logic              pw_changed;
    logic [FAIL_W-1:0] fail_count;

    int tests_run    = 0;
    int tests_failed = 0;

    lock_controller #(
        .DEFAULT_PASSWORD (16'h1234),
        .MAX_ATTEMPTS     (MAX_ATTEMPTS),
        .UNLOCK_CYCLES    (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES   (LOCKOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .storageFull (storageFull),
        .enter       (enter),
        .newPassword (newPassword),
        .clear_entry (clear_entry),
        .unlocked    (unlocked),
        .set_mode    (set_mode),
        .alarm       (alarm),
        .pw_changed  (pw_changed),
        .fail_count  (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_enter(input logic [15:0] d, input logic full);
        digits      = d;
        storageFull = full;
        enter       = 1'b1;
        tick();
        enter       = 1'b0;
    endtask

    task automatic press_new();
        newPassword = 1'b1;
        tick();
        newPassword = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".clear"},  {31'd0, clear_entry}, 32'd0);
        check({tag, ".unlk"},   {31'd0, unlocked},    32'd0);
        check({tag, ".set"},    {31'd0, set_mode},    32'd0);
        check({tag, ".alarm"},  {31'd0, alarm},       32'd0);
        check({tag, ".pwchg"},  {31'd0, pw_changed},  32'd0);
        check({tag, ".fails"},  32'(fail_count),      32'd0);
    endtask

    // Synchronous-looking reset pulse issued 1 ns after an edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        digits      = '0;
        storageFull = 1'b0;
        enter       = 1'b0;
        newPassword = 1'b0;
        idle(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: correct entry unlocks for exactly 8 cycles.
        press_enter(16'h1234, 1'b1);
        check("t1.unlk",  {31'd0, unlocked},    32'd1);
        check("t1.clear", {31'd0, clear_entry}, 32'd1);
        idle(7);
        check("t1.clr_pulse", {31'd0, clear_entry}, 32'd0);
        check("t1.unlk_last", {31'd0, unlocked},    32'd1);
        tick();
        check("t1.relock", {31'd0, unlocked}, 32'd0);

        // 2: three failures -> lockout; enter during lockout only clears.
        press_enter(16'h1111, 1'b1);
        check("t2.fail1", 32'(fail_count), 32'd1);
        check("t2.clr1",  {31'd0, clear_entry}, 32'd1);
        press_enter(16'h1111, 1'b1);
        check("t2.fail2", 32'(fail_count), 32'd2);
        check("t2.alarm_pre", {31'd0, alarm}, 32'd0);
        press_enter(16'h1111, 1'b1);
        check("t2.alarm", {31'd0, alarm}, 32'd1);
        check("t2.fail3", 32'(fail_count), 32'd3);
        press_enter(16'h1234, 1'b1);
        check("t2.lo_clear", {31'd0, clear_entry}, 32'd1);
        check("t2.lo_unlk",  {31'd0, unlocked},    32'd0);
        check("t2.lo_alarm", {31'd0, alarm},       32'd1);
        idle(14);
        check("t2.alarm_last", {31'd0, alarm}, 32'd1);
        tick();
        check("t2.alarm_off", {31'd0, alarm}, 32'd0);
        check("t2.fail_clr",  32'(fail_count), 32'd0);

        // 3: change password to 9876.
        press_enter(16'h1234, 1'b1);
        press_new();
        check("t3.set",   {31'd0, set_mode}, 32'd1);
        check("t3.unlk0", {31'd0, unlocked}, 32'd0);
        check("t3.clear", {31'd0, clear_entry}, 32'd1);
        press_enter(16'h9876, 1'b1);
        check("t3.pwchg",  {31'd0, pw_changed}, 32'd1);
        check("t3.set_off", {31'd0, set_mode},  32'd0);
        check("t3.locked", {31'd0, unlocked},   32'd0);
        tick();
        check("t3.pwchg_pulse", {31'd0, pw_changed}, 32'd0);
        press_enter(16'h1234, 1'b1);
        check("t3.old_fails", 32'(fail_count), 32'd1);
        check("t3.old_locked", {31'd0, unlocked}, 32'd0);
        press_enter(16'h9876, 1'b1);
        check("t3.new_unlk", {31'd0, unlocked}, 32'd1);
        check("t3.new_fail0", 32'(fail_count), 32'd0);
        press_enter(16'h0000, 1'b0);
        check("t3.enter_lock", {31'd0, unlocked}, 32'd0);

        // 4: short entry in SET_PW keeps set mode; timeout keeps old password.
        do_reset();
        press_enter(16'h1234, 1'b1);
        press_new();
        press_enter(16'h5555, 1'b0);
        check("t4.clear", {31'd0, clear_entry}, 32'd1);
        check("t4.set",   {31'd0, set_mode},    32'd1);
        check("t4.nochg", {31'd0, pw_changed},  32'd0);
        idle(6);
        check("t4.set_last", {31'd0, set_mode}, 32'd1);
        tick();
        check("t4.set_off", {31'd0, set_mode}, 32'd0);
        press_enter(16'h1234, 1'b1);
        check("t4.pw_kept", {31'd0, unlocked}, 32'd1);
        press_enter(16'h0000, 1'b0);

        // 5: success clears the failure count; short entry counts as a failure.
        press_enter(16'h4321, 1'b1);
        press_enter(16'h1235, 1'b1);
        check("t5.fail2", 32'(fail_count), 32'd2);
        press_enter(16'h1234, 1'b1);
        check("t5.unlk",  {31'd0, unlocked}, 32'd1);
        check("t5.fail0", 32'(fail_count),   32'd0);
        press_enter(16'h0000, 1'b0);
        press_enter(16'h1234, 1'b0);
        check("t5.short_fail", 32'(fail_count), 32'd1);
        check("t5.short_lock", {31'd0, unlocked}, 32'd0);

        // 6a: reset in SET_PW after committing 5555 -> async clear, default password back.
        do_reset();
        press_enter(16'h1234, 1'b1);
        press_new();
        press_enter(16'h5555, 1'b1);
        press_enter(16'h5555, 1'b1);
        press_new();
        check("t6.in_set", {31'd0, set_mode}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6.rst_set");
        reset = 1'b0;
        tick();
        press_enter(16'h5555, 1'b1);
        check("t6.pw_lost", {31'd0, unlocked}, 32'd0);
        press_enter(16'h1234, 1'b1);
        check("t6.pw_default", {31'd0, unlocked}, 32'd1);
        press_enter(16'h0000, 1'b0);

        // 6b: reset in LOCKOUT.
        press_enter(16'h0000, 1'b1);
        press_enter(16'h0000, 1'b1);
        press_enter(16'h0000, 1'b1);
        check("t6.in_lockout", {31'd0, alarm}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6.rst_lo");
        reset = 1'b0;
        tick();
        press_enter(16'h1234, 1'b1);
        check("t6.after_lo", {31'd0, unlocked}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
